// File: rtl/spart_tx.sv
// SPART transmit path: one-byte holding register feeding an 8N1 shift register, paced by the baud enable tick.
// txd and tbr come straight from flops; a full holding register at stop-bit end starts the next frame with no idle gap.
module spart_tx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       tx_wr,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       tbr,
  output logic       tx_busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [4:0] EN_LAST = 5'(OVERSAMPLE - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] thr_q, thr_d;
  logic       thr_full_q, thr_full_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [4:0] en_cnt_q, en_cnt_d;
  logic       txd_q, txd_d;
  logic       bit_end;
  logic       load_shift;

  assign bit_end = enable && (state_q != IDLE) && (en_cnt_q == EN_LAST);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    en_cnt_d   = en_cnt_q;
    load_shift = 1'b0;

    if ((state_q != IDLE) && enable) begin
      en_cnt_d = bit_end ? 5'd0 : en_cnt_q + 5'd1;
    end

    case (state_q)
      IDLE: begin
        // The tick coinciding with leaving IDLE is not part of the start bit.
        if (thr_full_q) begin
          state_d    = START;
          load_shift = 1'b1;
          en_cnt_d   = 5'd0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (thr_full_q) begin
            state_d    = START;
            load_shift = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_shift) begin
      shift_d = thr_q;
    end
  end

  // A transfer only happens with thr full, so a coincident write is already blocked by tbr=0.
  always_comb begin
    thr_d      = thr_q;
    thr_full_d = thr_full_q;
    if (load_shift) begin
      thr_full_d = 1'b0;
    end else if (tx_wr && !thr_full_q) begin
      thr_d      = tx_data;
      thr_full_d = 1'b1;
    end
  end

  always_comb begin
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      thr_q      <= 8'hFF;
      thr_full_q <= 1'b0;
      shift_q    <= 8'hFF;
      bit_cnt_q  <= 3'd0;
      en_cnt_q   <= 5'd0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      thr_q      <= thr_d;
      thr_full_q <= thr_full_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      en_cnt_q   <= en_cnt_d;
      txd_q      <= txd_d;
    end
  end

  assign txd     = txd_q;
  assign tbr     = ~thr_full_q;
  assign tx_busy = (state_q != IDLE);

endmodule

// File: doc/spart_tx.md
# spart_tx

SPART transmit path: accepts a byte from the bus interface into a one-byte holding register and serialises it on `txd` as an 8N1 frame (start bit 0, eight data bits LSB first, stop bit 1). Bit timing comes from the shared baud generator's `enable` tick, 16 ticks per bit, the same tick the receive path uses. Holding register plus shift register gives back-to-back frames with no idle gap.

## Interface
- `OVERSAMPLE`, default 16: enable ticks per bit period; legal range 2..32.
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `enable`  in  1  baud tick from baud generator, single-cycle pulses
- `tx_wr`  in  1  write strobe; loads `tx_data` into holding register when `tbr`=1
- `tx_data`  in  8  byte to transmit
- `txd`  out  1  serial output, idle high, registered
- `tbr`  out  1  transmit buffer ready (holding register empty), registered
- `tx_busy`  out  1  1 while a frame is on the line (state != IDLE)

## Operation
- State machine: IDLE, START, DATA, STOP. Registers: `thr[7:0]`, `thr_full`, `shift[7:0]`, `bit_cnt[2:0]`, `en_cnt[4:0]`.
- `tbr` = ~`thr_full`.
- Write: `tx_wr`=1 and `thr_full`=0 -> `thr`<=`tx_data`, `thr_full`<=1. Write with `thr_full`=1 is dropped; `thr` is unchanged and no error is flagged.
- IDLE, `txd`=1: if `thr_full`, next edge -> START, `shift`<=`thr`, `thr_full`<=0, `en_cnt`<=0.
- Bit timing, all non-IDLE states: each `enable`=1 cycle increments `en_cnt`. The bit ends on the edge where `enable`=1 and `en_cnt`==OVERSAMPLE-1; that edge sets `en_cnt`<=0 and advances. `enable` on the IDLE->START edge is not counted.
- START, `txd`=0: bit end -> DATA, `bit_cnt`<=0.
- DATA, `txd`=`shift[0]`: bit end -> `shift`<=`shift`>>1. If `bit_cnt`==7 -> STOP, else `bit_cnt`+1.
- STOP, `txd`=1: bit end -> if `thr_full`, START with `shift`<=`thr`, `thr_full`<=0 (back-to-back), else IDLE.
- A write in the same cycle as a holding->shift transfer cannot occur, because `tbr`=0 in that cycle; the write is dropped per the rule above.
- `txd` is driven from a flop decoded from the next state and `shift`, so no combinational glitches appear on the pin.
- Reset values: state IDLE, `txd`=1, `tbr`=1, `tx_busy`=0, `thr`=8'hFF, `shift`=8'hFF, `en_cnt`=0, `bit_cnt`=0.
- Reset mid-frame: the frame is aborted immediately (async), `txd` goes to 1, and holding contents are discarded.

## Timing
- Write sampled at edge k with the block idle: `tbr`=0 after edge k; after edge k+1 `txd`=0, `tx_busy`=1, `tbr`=1.
- Each bit lasts exactly OVERSAMPLE `enable` ticks. A frame is 10*OVERSAMPLE ticks.
- `tx_busy` falls on the stop-bit end edge when `thr` is empty. With `thr` full, `tx_busy` stays 1 and the next start bit begins on that same edge (zero idle clocks).
- `tbr` returns to 1 on the edge that moves `thr` into `shift`. A second byte may therefore be written during the start bit of the first.
- `enable` held continuously high is legal: one tick per clock.

## Test plan
- Reset: assert `rst` mid-frame -> `txd`=1, `tbr`=1, `tx_busy`=0 within the same cycle; no further transitions until a write.
- Single byte 8'hA5, `enable` every 4 clks: `txd` sequence 0,1,0,1,0,0,1,0,1,1, each level held 64 clks; `tx_busy` high for 640 clks.
- Back-to-back: write 8'h00, then write 8'hFF once `tbr` rises -> second start bit immediately follows first stop bit; `tx_busy` never drops; 20 bits total.
- Overrun: write 8'h3C, write 8'h55 (accepted into `thr`), then write 8'hAA while `tbr`=0 -> only 3C and 55 are transmitted; AA never appears.
- `enable` tied high: 8'h81 -> frame of 160 clks, bits 0,1,0,0,0,0,0,0,1,1.
- Loopback: `txd` into the SPART receive path, 256 random bytes -> every received byte matches.
